// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two one-entry buffered producers share the register-file write port.
// Optional combinational forwarding lookup is compiled in when WB_FWD_EN is defined.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic [CNT_W-1:0]  contention_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // Handshake: a transfer happens on a rising edge where reqN_valid && reqN_ready.
  // reqN_ready depends only on buffer state and this cycle's grant, never on reqN_valid.

  logic              buf0_full_q, buf0_full_d;
  logic [ADDR_W-1:0] buf0_addr_q, buf0_addr_d;
  logic [DATA_W-1:0] buf0_data_q, buf0_data_d;
  logic              buf1_full_q, buf1_full_d;
  logic [ADDR_W-1:0] buf1_addr_q, buf1_addr_d;
  logic [DATA_W-1:0] buf1_data_q, buf1_data_d;

  logic              rr_ptr_q, rr_ptr_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic grant0, grant1, any_grant, both_full;
  logic accept0, accept1, load0, load1;

  always_comb begin
    both_full = buf0_full_q && buf1_full_q;
    // rr_ptr only matters when both buffers compete.
    grant0    = buf0_full_q && (!buf1_full_q || !rr_ptr_q);
    grant1    = buf1_full_q && (!buf0_full_q ||  rr_ptr_q);
    any_grant = grant0 || grant1;
  end

  assign req0_ready = !buf0_full_q || grant0;
  assign req1_ready = !buf1_full_q || grant1;

  always_comb begin
    accept0 = req0_valid && req0_ready;
    accept1 = req1_valid && req1_ready;
    // Writes to r0 are swallowed at the handshake.
    load0   = accept0 && (req0_addr != '0);
    load1   = accept1 && (req1_addr != '0);
  end

  always_comb begin
    buf0_full_d = buf0_full_q;
    buf0_addr_d = buf0_addr_q;
    buf0_data_d = buf0_data_q;
    if (grant0) buf0_full_d = 1'b0;
    if (load0) begin
      buf0_full_d = 1'b1;
      buf0_addr_d = req0_addr;
      buf0_data_d = req0_data;
    end
  end

  always_comb begin
    buf1_full_d = buf1_full_q;
    buf1_addr_d = buf1_addr_q;
    buf1_data_d = buf1_data_q;
    if (grant1) buf1_full_d = 1'b0;
    if (load1) begin
      buf1_full_d = 1'b1;
      buf1_addr_d = req1_addr;
      buf1_data_d = req1_data;
    end
  end

  always_comb begin
    regwrite_d   = any_grant;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant0) begin
      write_reg_d  = buf0_addr_q;
      write_data_d = buf0_data_q;
      rr_ptr_d     = 1'b1;
    end else if (grant1) begin
      write_reg_d  = buf1_addr_q;
      write_data_d = buf1_data_q;
      rr_ptr_d     = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (both_full && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_full_q  <= 1'b0;
      buf0_addr_q  <= '0;
      buf0_data_q  <= '0;
      buf1_full_q  <= 1'b0;
      buf1_addr_q  <= '0;
      buf1_data_q  <= '0;
      rr_ptr_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      buf0_full_q  <= buf0_full_d;
      buf0_addr_q  <= buf0_addr_d;
      buf0_data_q  <= buf0_data_d;
      buf1_full_q  <= buf1_full_d;
      buf1_addr_q  <= buf1_addr_d;
      buf1_data_q  <= buf1_data_d;
      rr_ptr_q     <= rr_ptr_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign RegWrite       = regwrite_q;
  assign WriteReg       = write_reg_q;
  assign WriteData      = write_data_q;
  assign contention_cnt = cnt_q;
  assign busy           = buf0_full_q || buf1_full_q || regwrite_q;

`ifdef WB_FWD_EN
  // Buffers hold newer values than the output register; buf1 wins a tie.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if (buf1_full_q && (buf1_addr_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf1_data_q;
      end else if (buf0_full_q && (buf0_addr_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf0_data_q;
      end else if (regwrite_q && (write_reg_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (narrow contention counter keeps the saturation run short).
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              busy;
  logic [CNT_W-1:0]  contention_cnt;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  int passed = 0;
  int total  = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .busy(busy), .contention_cnt(contention_cnt)
`ifdef WB_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
`ifdef WB_FWD_EN
    fwd_addr = '0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive0(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req0_valid = v; req0_addr = a; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req1_valid = v; req1_addr = a; req1_data = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    total++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite: got %0b want 0", RegWrite); else passed++;
    total++; if (WriteReg !== 5'd0) $display("FAIL reset_writereg: got %0h want 0", WriteReg); else passed++;
    total++; if (WriteData !== 32'd0) $display("FAIL reset_writedata: got %0h want 0", WriteData); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (contention_cnt !== 8'd0) $display("FAIL reset_cnt: got %0h want 0", contention_cnt); else passed++;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1)
      $display("FAIL reset_ready: got %0b%0b want 11", req0_ready, req1_ready); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    drive0(1'b1, 5'd5, 32'hDEADBEEF);
    total++; if (req0_ready !== 1'b1) $display("FAIL single_ready_pre: got %0b want 1", req0_ready); else passed++;
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    total++; if (RegWrite !== 1'b0) $display("FAIL single_rw_n1: got %0b want 0", RegWrite); else passed++;
    total++; if (req0_ready !== 1'b1) $display("FAIL single_ready_n1: got %0b want 1", req0_ready); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy_n1: got %0b want 1", busy); else passed++;
    tick();
    total++; if (RegWrite !== 1'b1) $display("FAIL single_rw_n2: got %0b want 1", RegWrite); else passed++;
    total++; if (WriteReg !== 5'd5) $display("FAIL single_reg: got %0d want 5", WriteReg); else passed++;
    total++; if (WriteData !== 32'hDEADBEEF) $display("FAIL single_data: got %0h want deadbeef", WriteData); else passed++;
    total++; if (req0_ready !== 1'b1) $display("FAIL single_ready_n2: got %0b want 1", req0_ready); else passed++;
    tick();
    total++; if (RegWrite !== 1'b0) $display("FAIL single_rw_n3: got %0b want 0", RegWrite); else passed++;
    total++; if (WriteReg !== 5'd5) $display("FAIL single_reg_hold: got %0d want 5", WriteReg); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_n3: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_contention();
    do_reset();
    drive0(1'b1, 5'd1, 32'h11);
    drive1(1'b1, 5'd2, 32'h22);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL cont_ready_c0: got %0b%0b want 10", req0_ready, req1_ready); else passed++;
    tick();
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd1 || WriteData !== 32'h11)
      $display("FAIL cont_issue1: got rw=%0b r%0d=%0h want rw=1 r1=11", RegWrite, WriteReg, WriteData); else passed++;
    total++; if (contention_cnt !== 8'd1) $display("FAIL cont_cnt1: got %0d want 1", contention_cnt); else passed++;
    tick();
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd2 || WriteData !== 32'h22)
      $display("FAIL cont_issue2: got rw=%0b r%0d=%0h want rw=1 r2=22", RegWrite, WriteReg, WriteData); else passed++;
    total++; if (contention_cnt !== 8'd1) $display("FAIL cont_cnt_hold: got %0d want 1", contention_cnt); else passed++;
    tick();
    total++; if (RegWrite !== 1'b0 || busy !== 1'b0)
      $display("FAIL cont_idle: got rw=%0b busy=%0b want 0 0", RegWrite, busy); else passed++;
    // rr_ptr should be back at 0, so port 0 wins again
    drive0(1'b1, 5'd3, 32'h33);
    drive1(1'b1, 5'd4, 32'h44);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    tick();
    total++; if (WriteReg !== 5'd3 || WriteData !== 32'h33)
      $display("FAIL cont_rr_first: got r%0d=%0h want r3=33", WriteReg, WriteData); else passed++;
    tick();
    total++; if (WriteReg !== 5'd4 || WriteData !== 32'h44)
      $display("FAIL cont_rr_second: got r%0d=%0h want r4=44", WriteReg, WriteData); else passed++;
    total++; if (contention_cnt !== 8'd2) $display("FAIL cont_cnt2: got %0d want 2", contention_cnt); else passed++;
    tick();
  endtask

  task automatic test_streaming();
    do_reset();
    drive0(1'b1, 5'd8, 32'hA0);
    drive1(1'b1, 5'd9, 32'hB1);
    for (int k = 1; k <= 20; k++) begin
      logic              exp_r0;
      logic [ADDR_W-1:0] exp_reg;
      logic [DATA_W-1:0] exp_data;
      tick();
      exp_r0   = (k % 2 == 1);
      exp_reg  = (k % 2 == 0) ? 5'd8 : 5'd9;
      exp_data = (k % 2 == 0) ? 32'hA0 : 32'hB1;
      total++; if (req0_ready !== exp_r0 || req1_ready !== !exp_r0)
        $display("FAIL stream_ready k=%0d: got %0b%0b want %0b%0b", k, req0_ready, req1_ready, exp_r0, !exp_r0);
      else passed++;
      total++; if (contention_cnt !== CNT_W'(k - 1))
        $display("FAIL stream_cnt k=%0d: got %0d want %0d", k, contention_cnt, k - 1); else passed++;
      if (k == 1) begin
        total++; if (RegWrite !== 1'b0) $display("FAIL stream_rw_first: got %0b want 0", RegWrite); else passed++;
      end else begin
        total++; if (RegWrite !== 1'b1 || WriteReg !== exp_reg || WriteData !== exp_data)
          $display("FAIL stream_issue k=%0d: got rw=%0b r%0d=%0h want rw=1 r%0d=%0h",
                   k, RegWrite, WriteReg, WriteData, exp_reg, exp_data);
        else passed++;
      end
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_r0_discard();
    do_reset();
    drive0(1'b1, 5'd0, 32'h1234);
    total++; if (req0_ready !== 1'b1) $display("FAIL r0_ready0: got %0b want 1", req0_ready); else passed++;
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b1, 5'd0, 32'h1234);
    total++; if (req1_ready !== 1'b1) $display("FAIL r0_ready1: got %0b want 1", req1_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL r0_busy_p0: got %0b want 0", busy); else passed++;
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      total++; if (RegWrite !== 1'b0 || busy !== 1'b0)
        $display("FAIL r0_nowrite i=%0d: got rw=%0b busy=%0b want 0 0", i, RegWrite, busy); else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive0(1'b1, 5'd10, 32'h100 + i);
      tick();
      total++; if (req0_ready !== 1'b1) $display("FAIL b2b_ready i=%0d: got %0b want 1", i, req0_ready); else passed++;
      if (i >= 1) begin
        total++; if (RegWrite !== 1'b1 || WriteData !== 32'h100 + i - 1)
          $display("FAIL b2b_issue i=%0d: got rw=%0b %0h want rw=1 %0h", i, RegWrite, WriteData, 32'h100 + i - 1);
        else passed++;
      end
    end
    drive0(1'b0, 5'd0, 32'd0);
    tick();
    total++; if (RegWrite !== 1'b1 || WriteData !== 32'h105)
      $display("FAIL b2b_last: got rw=%0b %0h want rw=1 105", RegWrite, WriteData); else passed++;
    tick();
    total++; if (RegWrite !== 1'b0) $display("FAIL b2b_done: got %0b want 0", RegWrite); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    drive0(1'b1, 5'd12, 32'h5A);
    drive1(1'b1, 5'd13, 32'hA5);
    for (int k = 1; k <= 270; k++) begin
      tick();
      if (k == 255) begin
        total++; if (contention_cnt !== 8'hFE) $display("FAIL sat_minus1: got %0h want fe", contention_cnt); else passed++;
      end
      if (k == 256) begin
        total++; if (contention_cnt !== 8'hFF) $display("FAIL sat_reach: got %0h want ff", contention_cnt); else passed++;
      end
    end
    total++; if (contention_cnt !== 8'hFF) $display("FAIL sat_hold: got %0h want ff", contention_cnt); else passed++;
    idle_inputs();
    repeat (3) tick();
    total++; if (contention_cnt !== 8'hFF) $display("FAIL sat_idle_hold: got %0h want ff", contention_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive0(1'b1, 5'd11, 32'h55);
    drive1(1'b1, 5'd12, 32'h66);
    tick();
    tick();
    total++; if (RegWrite !== 1'b1 || busy !== 1'b1)
      $display("FAIL rstmid_pre: got rw=%0b busy=%0b want 1 1", RegWrite, busy); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (RegWrite !== 1'b0) $display("FAIL rstmid_rw: got %0b want 0", RegWrite); else passed++;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1)
      $display("FAIL rstmid_ready: got %0b%0b want 11", req0_ready, req1_ready); else passed++;
    total++; if (busy !== 1'b0 || contention_cnt !== 8'd0)
      $display("FAIL rstmid_state: got busy=%0b cnt=%0d want 0 0", busy, contention_cnt); else passed++;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (RegWrite !== 1'b0 || busy !== 1'b0)
        $display("FAIL rstmid_after i=%0d: got rw=%0b busy=%0b want 0 0", i, RegWrite, busy); else passed++;
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forwarding();
    do_reset();
    drive0(1'b1, 5'd7, 32'hB);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b1, 5'd7, 32'hA);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    fwd_addr = 5'd7;
    #1;
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hA)
      $display("FAIL fwd_buf1: got hit=%0b %0h want 1 a", fwd_hit, fwd_data); else passed++;
    fwd_addr = 5'd0;
    #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0)
      $display("FAIL fwd_r0: got hit=%0b %0h want 0 0", fwd_hit, fwd_data); else passed++;
    fwd_addr = 5'd7;
    tick();
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hA)
      $display("FAIL fwd_outreg: got hit=%0b %0h want 1 a", fwd_hit, fwd_data); else passed++;
    tick();
    total++; if (fwd_hit !== 1'b0) $display("FAIL fwd_miss: got %0b want 0", fwd_hit); else passed++;
    fwd_addr = 5'd0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_streaming();
    test_r0_discard();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_forwarding();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
